instr_word_encoder_loader: RTL

//  Inverse of the control-word decode path: packs per-field control values (opcode, RW, MD, BS,
//  PS, MW, FS, MA, MB, AA, BA, CS) into 32-bit instruction words, buffers them in a small FIFO
//  and writes them sequentially into instruction memory from BASE_ADDR. Used by the

---
 rtl/instr_fmt_pkg.sv | 72 +++++++
 rtl/instr_word_fifo.sv | 67 ++++++
 rtl/instr_word_encoder_loader.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/instr_fmt_pkg.sv
// rtl/instr_fmt_pkg.sv - instruction word field layout, loader FSM states, word packer
//
// Purpose: shared definitions for the instruction word encoder/loader.
//   Field LSB/width constants for the 32-bit control word, the loader state
//   enum and pack_instr(), which concatenates per-field values into one word.
// Ports: none (package).
package instr_fmt_pkg;

  localparam int OPC_LSB = 25;
  localparam int OPC_W   = 7;
  localparam int RW_LSB  = 24;
  localparam int RW_W    = 1;
  localparam int MD_LSB  = 22;
  localparam int MD_W    = 2;
  localparam int BS_LSB  = 20;
  localparam int BS_W    = 2;
  localparam int PS_LSB  = 19;
  localparam int PS_W    = 1;
  localparam int MW_LSB  = 18;
  localparam int MW_W    = 1;
  localparam int FS_LSB  = 13;
  localparam int FS_W    = 5;
  localparam int MA_LSB  = 12;
  localparam int MA_W    = 1;
  localparam int MB_LSB  = 11;
  localparam int MB_W    = 1;
  localparam int AA_LSB  = 6;
  localparam int AA_W    = 5;
  localparam int BA_LSB  = 1;
  localparam int BA_W    = 5;
  localparam int CS_LSB  = 0;
  localparam int CS_W    = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } enc_state_e;

  function automatic logic [31:0] pack_instr(
    input logic [OPC_W-1:0] opcode,
    input logic [RW_W-1:0]  rw,
    input logic [MD_W-1:0]  md,
    input logic [BS_W-1:0]  bs,
    input logic [PS_W-1:0]  ps,
    input logic [MW_W-1:0]  mw,
    input logic [FS_W-1:0]  fs,
    input logic [MA_W-1:0]  ma,
    input logic [MB_W-1:0]  mb,
    input logic [AA_W-1:0]  aa,
    input logic [BA_W-1:0]  ba,
    input logic [CS_W-1:0]  cs
  );
    logic [31:0] w;
    w = '0;
    w[OPC_LSB +: OPC_W] = opcode;
    w[RW_LSB  +: RW_W]  = rw;
    w[MD_LSB  +: MD_W]  = md;
    w[BS_LSB  +: BS_W]  = bs;
    w[PS_LSB  +: PS_W]  = ps;
    w[MW_LSB  +: MW_W]  = mw;
    w[FS_LSB  +: FS_W]  = fs;
    w[MA_LSB  +: MA_W]  = ma;
    w[MB_LSB  +: MB_W]  = mb;
    w[AA_LSB  +: AA_W]  = aa;
    w[BA_LSB  +: BA_W]  = ba;
    w[CS_LSB  +: CS_W]  = cs;
    return w;
  endfunction

endpackage

// File: rtl/instr_word_fifo.sv
// rtl/instr_word_fifo.sv - synchronous FIFO buffering encoded instruction words
//
// Purpose: small single-clock FIFO between the encoder and the imem writer.
//   Push and pop may occur in the same cycle; a push while full or a pop
//   while empty is dropped.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset (pointers/count cleared)
//   push_i   in   write wdata_i at tail
//   wdata_i  in   WIDTH data to push
//   pop_i    in   drop head entry
//   rdata_o  out  WIDTH head entry (undefined content when empty)
//   full_o   out  DEPTH entries held
//   empty_o  out  no entries held
module instr_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/instr_word_encoder_loader.sv
// rtl/instr_word_encoder_loader.sv - packs control fields into words and loads them into imem
//
// Purpose: accepts per-field control tuples, packs each into a 32-bit
//   instruction word, buffers it in instr_word_fifo and writes the words to
//   consecutive imem addresses starting at BASE_ADDR.
//   Optional macro INSTR_ENC_CHKSUM_EN: keeps an XOR checksum of the words
//   written this session; without it chksum is tied to zero.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start                   pulse: begin a load session (only honoured in IDLE)
//   in_valid/in_ready       tuple handshake; in_last marks the final tuple
//   opcode..cs              control fields to pack
//   imem_we/imem_ready      imem write handshake
//   imem_addr/imem_wdata    write address / encoded word
//   busy                    session active (state != IDLE)
//   done                    one-cycle pulse at session end
//   ovf                     sticky: address wrapped past the top of imem
//   chksum                  XOR of committed words this session
module instr_word_encoder_loader
  import instr_fmt_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                DEPTH     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [6:0]        opcode,
  input  logic              rw,
  input  logic [1:0]        md,
  input  logic [1:0]        bs,
  input  logic              ps,
  input  logic              mw,
  input  logic [4:0]        fs,
  input  logic              ma,
  input  logic              mb,
  input  logic [4:0]        aa,
  input  logic [4:0]        ba,
  input  logic              cs,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [31:0]       chksum
);

  enc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ovf_q, ovf_d;

  logic              fifo_full;
  logic              fifo_empty;
  logic [31:0]       fifo_head;
  logic [31:0]       word;
  logic              accept;
  logic              commit;
  logic              session_start;

  assign word = pack_instr(opcode, rw, md, bs, ps, mw, fs, ma, mb, aa, ba, cs);

  assign in_ready      = (state_q == LOAD) & ~fifo_full;
  assign accept        = in_valid & in_ready;
  assign imem_we       = ~fifo_empty & ((state_q == LOAD) | (state_q == DRAIN));
  assign commit        = imem_we & imem_ready;
  assign session_start = (state_q == IDLE) & start;

  // Data is gated so the bus reads zero whenever no write is requested.
  assign imem_wdata = imem_we ? fifo_head : 32'h0;
  assign imem_addr  = addr_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign ovf        = ovf_q;

  instr_word_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (accept),
    .wdata_i (word),
    .pop_i   (commit),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= BASE_ADDR;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          addr_d  = BASE_ADDR;
          ovf_d   = 1'b0;
        end
      end
      LOAD: begin
        if (accept && in_last) state_d = DRAIN;
      end
      DRAIN: begin
        // Empty FIFO means the final commit has already happened.
        if (fifo_empty) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Commits only occur in LOAD/DRAIN, so they never collide with start.
    if (commit) begin
      addr_d = addr_q + ADDR_W'(1);
      if (addr_q == {ADDR_W{1'b1}}) ovf_d = 1'b1;
    end
  end

`ifdef INSTR_ENC_CHKSUM_EN
  logic [31:0] chk_q, chk_d;

  always_comb begin
    chk_d = chk_q;
    if (session_start) begin
      chk_d = 32'h0;
    end else if (commit) begin
      chk_d = chk_q ^ imem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_q <= 32'h0;
    end else begin
      chk_q <= chk_d;
    end
  end

  assign chksum = chk_q;
`else
  logic unused_start;
  assign unused_start = session_start;
  assign chksum       = 32'h0;
`endif

endmodule
